// File: rtl/fifo_unpack_lanes.sv
// fifo_unpack_lanes
//
// Width down-converter sitting between the SDRAM read FIFO and the VGA
// pixel FIFO. Each input word carries LANES pixels of OUT_W bits plus a
// lane-count tag. Tag 0 means all LANES pixels are valid. Tag k means only
// the first k lanes are valid. Every valid pixel is written to the output
// FIFO one at a time. Back-to-back words stream with no idle cycles, and
// the output FIFO's full flag stalls the converter without losing or
// repeating a pixel. Everything runs on the rising edge of iCLK.
//
// Parameters
//   OUT_W  pixel width (bits per output write)
//   LANES  pixels per input word (>= 2)
//
// Ports
//   iCLK           sole clock, shared with both FIFOs
//   iRST           asynchronous reset, active-high
//   iINFIFO_EMPTY  input FIFO empty
//   iINFIFO_DATA   {tag, lanes}; valid the cycle after oINFIFO_RDREQ
//   oINFIFO_RDREQ  input FIFO read request
//   iOUTFIFO_FULL  output FIFO full (backpressure)
//   oOUTFIFO_DATA  pixel to write
//   oOUTFIFO_WEN   output FIFO write enable
//   oBUSY          high while a word is being unpacked
//
// Configuration macro
//   UNPACK_LSB_FIRST_EN  when defined, lane 0 is the least significant
//                        pixel and lanes ascend towards the MSB, so a
//                        partial tag keeps the lowest k lanes. When it is
//                        undefined, lane 0 is the most significant pixel.
module fifo_unpack_lanes #(
    parameter int OUT_W = 8,
    parameter int LANES = 2
) (
    input  logic                                      iCLK,
    input  logic                                      iRST,
    input  logic                                      iINFIFO_EMPTY,
    input  logic [$clog2(LANES)+OUT_W*LANES-1:0]      iINFIFO_DATA,
    output logic                                      oINFIFO_RDREQ,
    input  logic                                      iOUTFIFO_FULL,
    output logic [OUT_W-1:0]                          oOUTFIFO_DATA,
    output logic                                      oOUTFIFO_WEN,
    output logic                                      oBUSY
);

    localparam int IN_W  = OUT_W * LANES;
    localparam int CNT_W = $clog2(LANES);
    localparam int NL_W  = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } stateT;

    stateT              state;
    stateT              nextState;
    logic [IN_W-1:0]    wordR;
    logic [CNT_W-1:0]   laneCnt;
    logic [NL_W-1:0]    nLanesR;

    logic [CNT_W-1:0]   tagIn;
    logic [IN_W-1:0]    wordIn;
    logic [NL_W-1:0]    nLanesIn;
    logic               lastEmit;

    logic               rdReq;
    logic               wen;
    logic [OUT_W-1:0]   pixel;
    logic               loadWord;
    logic               incLane;

    // Picks one lane out of a packed word. The order of lanes depends on
    // the build option.
    function automatic logic [OUT_W-1:0] laneOf(input logic [IN_W-1:0]  w,
                                                input logic [CNT_W-1:0] idx);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx == CNT_W'(i)) begin
`ifdef UNPACK_LSB_FIRST_EN
                r = w[i*OUT_W +: OUT_W];
`else
                r = w[IN_W-1-i*OUT_W -: OUT_W];
`endif
            end
        end
        return r;
    endfunction

    assign tagIn  = iINFIFO_DATA[CNT_W+IN_W-1 -: CNT_W];
    assign wordIn = iINFIFO_DATA[IN_W-1:0];

    // Decodes the tag into a lane count. Tag 0 means a full word. A tag
    // above LANES is treated as a full word, so an illegal tag can never
    // leave the converter waiting for a lane that does not exist.
    always_comb begin
        nLanesIn = NL_W'(LANES);
        if ((tagIn != '0) && (NL_W'(tagIn) <= NL_W'(LANES))) begin
            nLanesIn = NL_W'(tagIn);
        end
    end

    assign lastEmit = (NL_W'(laneCnt) == (nLanesR - NL_W'(1)));

    // Next-state and output logic. In ST_LOAD, lane 0 comes straight from
    // the FIFO output. This saves a cycle, and a new read is issued in the
    // same cycle as the last lane of the current word, so full words
    // stream with no gap between them.
    always_comb begin
        nextState = state;
        rdReq     = 1'b0;
        wen       = 1'b0;
        pixel     = '0;
        loadWord  = 1'b0;
        incLane   = 1'b0;
        case (state)
            ST_IDLE: begin
                rdReq = !iINFIFO_EMPTY;
                if (rdReq) begin
                    nextState = ST_LOAD;
                end
            end
            ST_LOAD: begin
                loadWord = 1'b1;
                pixel    = laneOf(wordIn, '0);
                wen      = !iOUTFIFO_FULL;
                if (iOUTFIFO_FULL) begin
                    nextState = ST_EMIT;
                end else if (nLanesIn == NL_W'(1)) begin
                    rdReq     = !iINFIFO_EMPTY;
                    nextState = rdReq ? ST_LOAD : ST_IDLE;
                end else begin
                    nextState = ST_EMIT;
                end
            end
            ST_EMIT: begin
                pixel = laneOf(wordR, laneCnt);
                wen   = !iOUTFIFO_FULL;
                if (!iOUTFIFO_FULL) begin
                    if (lastEmit) begin
                        rdReq     = !iINFIFO_EMPTY;
                        nextState = rdReq ? ST_LOAD : ST_IDLE;
                    end else begin
                        incLane = 1'b1;
                    end
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // State register and word buffer. A word is captured only in ST_LOAD.
    // ST_LOAD is entered only after the previous word's last lane has been
    // written, so the buffer is never overwritten while it still holds
    // unsent lanes. If the output is full during load, lane 0 is resent
    // from the buffer.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state   <= ST_IDLE;
            wordR   <= '0;
            laneCnt <= '0;
            nLanesR <= '0;
        end else begin
            state <= nextState;
            if (loadWord) begin
                wordR   <= wordIn;
                nLanesR <= nLanesIn;
                laneCnt <= iOUTFIFO_FULL ? '0 : CNT_W'(1);
            end else if (incLane) begin
                laneCnt <= laneCnt + CNT_W'(1);
            end
        end
    end

    // All outputs are forced low while reset is held. Otherwise ST_IDLE
    // would raise a read request as soon as the input FIFO is non-empty.
    assign oINFIFO_RDREQ = rdReq & ~iRST;
    assign oOUTFIFO_WEN  = wen & ~iRST;
    assign oOUTFIFO_DATA = iRST ? '0 : pixel;
    assign oBUSY         = (state != ST_IDLE) & ~iRST;

endmodule

// File: tb/tb_fifo_unpack_lanes.sv
// Testbench for fifo_unpack_lanes.
// Two instances are exercised: the default LANES=2 build and a LANES=4
// build. Each one is fed by a small FIFO model that returns data the cycle
// after a read request. Expected pixels are queued when a word is pushed.
// They are popped and compared when the DUT writes a pixel.
module tb_fifo_unpack_lanes;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        full;

    logic        empty2;
    logic [16:0] q2 = '0;
    logic        rdreq2;
    logic [7:0]  data2;
    logic        wen2;
    logic        busy2;

    logic        empty4;
    logic [33:0] q4 = '0;
    logic        rdreq4;
    logic [7:0]  data4;
    logic        wen4;
    logic        busy4;

    logic [16:0] mem2 [0:31];
    logic [33:0] mem4 [0:15];
    int          wr2 = 0;
    int          rd2 = 0;
    int          wr4 = 0;
    int          rd4 = 0;

    logic [7:0]  expQ2 [$];
    logic [7:0]  expQ4 [$];

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cycle <= cycle + 1;

    fifo_unpack_lanes dut2 (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iINFIFO_EMPTY (empty2),
        .iINFIFO_DATA  (q2),
        .oINFIFO_RDREQ (rdreq2),
        .iOUTFIFO_FULL (full),
        .oOUTFIFO_DATA (data2),
        .oOUTFIFO_WEN  (wen2),
        .oBUSY         (busy2)
    );

    fifo_unpack_lanes #(.OUT_W(8), .LANES(4)) dut4 (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iINFIFO_EMPTY (empty4),
        .iINFIFO_DATA  (q4),
        .oINFIFO_RDREQ (rdreq4),
        .iOUTFIFO_FULL (full),
        .oOUTFIFO_DATA (data4),
        .oOUTFIFO_WEN  (wen4),
        .oBUSY         (busy4)
    );

    // Input FIFO models: the registered output appears the cycle after a
    // read request.
    assign empty2 = (wr2 == rd2);
    assign empty4 = (wr4 == rd4);

    always @(posedge iCLK) begin
        if (rdreq2 && (rd2 != wr2)) begin
            q2  <= mem2[rd2];
            rd2 <= rd2 + 1;
        end
    end

    always @(posedge iCLK) begin
        if (rdreq4 && (rd4 != wr4)) begin
            q4  <= mem4[rd4];
            rd4 <= rd4 + 1;
        end
    end

    // Reference lane order: MSB-first by default, LSB-first with the
    // build option.
    function automatic logic [7:0] expLane(input logic [31:0] w, input int lanes, input int i);
        logic [31:0] s;
`ifdef UNPACK_LSB_FIRST_EN
        s = w >> (i * 8);
`else
        s = w >> ((lanes - 1 - i) * 8);
`endif
        return s[7:0];
    endfunction

    task automatic pushWord2(input logic tag, input logic [15:0] w);
        int n;
        n = (tag == 1'b0) ? 2 : 1;
        mem2[wr2] = {tag, w};
        wr2 = wr2 + 1;
        for (int i = 0; i < n; i++) expQ2.push_back(expLane({16'h0, w}, 2, i));
    endtask

    task automatic pushWord4(input logic [1:0] tag, input logic [31:0] w);
        int n;
        n = (tag == 2'd0) ? 4 : int'(tag);
        mem4[wr4] = {tag, w};
        wr4 = wr4 + 1;
        for (int i = 0; i < n; i++) expQ4.push_back(expLane(w, 4, i));
    endtask

    task automatic test_reset();
        logic [7:0] e;
        int strays;
        iRST = 1'b1;
        full = 1'b0;
        repeat (2) @(negedge iCLK);
        pushWord2(1'b0, 16'h1122);
        @(negedge iCLK);
        total++; if (rdreq2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdreq got=%0b want=0", rdreq2); end
        total++; if (wen2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen got=%0b want=0", wen2); end
        total++; if (data2 !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", data2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy2); end
        @(posedge iCLK); #1 iRST = 1'b0;
        for (int c = 0; c < 40 && expQ2.size() > 0; c++) begin
            @(negedge iCLK);
            if (wen2) begin
                e = expQ2.pop_front();
                total++;
                if (data2 !== e) begin bad++; $display("[TB] FAIL reset_px got=%h want=%h", data2, e); end
            end
        end
        total++;
        if (expQ2.size() != 0) begin bad++; $display("[TB] FAIL reset_drain got=%0d left want=0", expQ2.size()); expQ2.delete(); end
        strays = 0;
        repeat (3) begin @(negedge iCLK); if (wen2) strays++; end
        total++; if (strays != 0) begin bad++; $display("[TB] FAIL reset_stray got=%0d want=0", strays); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle got=%0b want=0", busy2); end
    endtask

    task automatic test_stream();
        logic [7:0] e;
        int firstC, lastC, n;
        @(negedge iCLK);
        pushWord2(1'b0, 16'h1122);
        pushWord2(1'b0, 16'h3344);
        pushWord2(1'b0, 16'h5566);
        firstC = -1; lastC = -1; n = 0;
        for (int c = 0; c < 40 && expQ2.size() > 0; c++) begin
            @(negedge iCLK);
            if (wen2) begin
                if (firstC < 0) firstC = cycle;
                lastC = cycle;
                n++;
                e = expQ2.pop_front();
                total++;
                if (data2 !== e) begin bad++; $display("[TB] FAIL stream_px got=%h want=%h", data2, e); end
            end
        end
        total++;
        if (expQ2.size() != 0) begin bad++; $display("[TB] FAIL stream_drain got=%0d left want=0", expQ2.size()); expQ2.delete(); end
        total++; if (n != 6) begin bad++; $display("[TB] FAIL stream_count got=%0d want=6", n); end
        total++; if (lastC - firstC != 5) begin bad++; $display("[TB] FAIL stream_span got=%0d want=5", lastC - firstC); end
        repeat (2) @(negedge iCLK);
        total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL stream_idle got=%0b want=0", busy2); end
    endtask

    task automatic test_partial();
        logic [7:0] e;
        int strays, n;
        @(negedge iCLK);
        pushWord2(1'b1, 16'hAB10);
        n = 0;
        for (int c = 0; c < 20 && expQ2.size() > 0; c++) begin
            @(negedge iCLK);
            if (wen2) begin
                n++;
                e = expQ2.pop_front();
                total++;
                if (data2 !== e) begin bad++; $display("[TB] FAIL partial_px got=%h want=%h", data2, e); end
            end
        end
        total++;
        if (expQ2.size() != 0) begin bad++; $display("[TB] FAIL partial_drain got=%0d left want=0", expQ2.size()); expQ2.delete(); end
        strays = 0;
        repeat (3) begin @(negedge iCLK); if (wen2) strays++; end
        total++; if (n + strays != 1) begin bad++; $display("[TB] FAIL partial_count got=%0d want=1", n + strays); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL partial_idle got=%0b want=0", busy2); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e, held;
        logic got;
        int strays;
        @(negedge iCLK);
        pushWord2(1'b0, 16'hC0DE);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge iCLK);
            if (wen2) begin
                got = 1'b1;
                e = expQ2.pop_front();
                total++;
                if (data2 !== e) begin bad++; $display("[TB] FAIL bp_first got=%h want=%h", data2, e); end
            end
        end
        total++; if (!got) begin bad++; $display("[TB] FAIL bp_start got=nowrite want=write"); end
        held = (expQ2.size() > 0) ? expQ2[0] : 8'h00;
        @(posedge iCLK); #1 full = 1'b1;
        repeat (3) begin
            @(negedge iCLK);
            total++; if (wen2 !== 1'b0) begin bad++; $display("[TB] FAIL bp_wen got=%0b want=0", wen2); end
            total++; if (data2 !== held) begin bad++; $display("[TB] FAIL bp_hold got=%h want=%h", data2, held); end
        end
        total++; if (busy2 !== 1'b1) begin bad++; $display("[TB] FAIL bp_busy got=%0b want=1", busy2); end
        @(posedge iCLK); #1 full = 1'b0;
        for (int c = 0; c < 20 && expQ2.size() > 0; c++) begin
            @(negedge iCLK);
            if (wen2) begin
                e = expQ2.pop_front();
                total++;
                if (data2 !== e) begin bad++; $display("[TB] FAIL bp_px got=%h want=%h", data2, e); end
            end
        end
        total++;
        if (expQ2.size() != 0) begin bad++; $display("[TB] FAIL bp_drain got=%0d left want=0", expQ2.size()); expQ2.delete(); end
        strays = 0;
        repeat (3) begin @(negedge iCLK); if (wen2) strays++; end
        total++; if (strays != 0) begin bad++; $display("[TB] FAIL bp_dup got=%0d want=0", strays); end
    endtask

    task automatic test_lanes4();
        logic [7:0] e;
        int strays;
        @(negedge iCLK);
        pushWord4(2'd3, 32'h01020304);
        pushWord4(2'd0, 32'hA1B2C3D4);
        for (int c = 0; c < 40 && expQ4.size() > 0; c++) begin
            @(negedge iCLK);
            if (wen4) begin
                e = expQ4.pop_front();
                total++;
                if (data4 !== e) begin bad++; $display("[TB] FAIL l4_px got=%h want=%h", data4, e); end
            end
        end
        total++;
        if (expQ4.size() != 0) begin bad++; $display("[TB] FAIL l4_drain got=%0d left want=0", expQ4.size()); expQ4.delete(); end
        strays = 0;
        repeat (3) begin @(negedge iCLK); if (wen4) strays++; end
        total++; if (strays != 0) begin bad++; $display("[TB] FAIL l4_stray got=%0d want=0", strays); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL l4_idle got=%0b want=0", busy4); end
    endtask

    task automatic test_reset_midword();
        logic [7:0] e;
        logic got;
        int strays;
        @(negedge iCLK);
        pushWord2(1'b0, 16'hA5A5);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge iCLK);
            if (wen2) begin
                got = 1'b1;
                e = expQ2.pop_front();
                total++;
                if (data2 !== e) begin bad++; $display("[TB] FAIL rm_first got=%h want=%h", data2, e); end
            end
        end
        total++; if (!got) begin bad++; $display("[TB] FAIL rm_start got=nowrite want=write"); end
        @(posedge iCLK); #1 iRST = 1'b1;
        #1;
        expQ2.delete();
        total++; if (rdreq2 !== 1'b0) begin bad++; $display("[TB] FAIL rm_rdreq got=%0b want=0", rdreq2); end
        total++; if (wen2 !== 1'b0) begin bad++; $display("[TB] FAIL rm_wen got=%0b want=0", wen2); end
        total++; if (data2 !== 8'h00) begin bad++; $display("[TB] FAIL rm_data got=%h want=00", data2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL rm_busy got=%0b want=0", busy2); end
        @(posedge iCLK); #1 iRST = 1'b0;
        strays = 0;
        repeat (3) begin @(negedge iCLK); if (wen2) strays++; end
        total++; if (strays != 0) begin bad++; $display("[TB] FAIL rm_stray got=%0d want=0", strays); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL rm_idle got=%0b want=0", busy2); end
        pushWord2(1'b0, 16'h1234);
        for (int c = 0; c < 20 && expQ2.size() > 0; c++) begin
            @(negedge iCLK);
            if (wen2) begin
                e = expQ2.pop_front();
                total++;
                if (data2 !== e) begin bad++; $display("[TB] FAIL rm_next got=%h want=%h", data2, e); end
            end
        end
        total++;
        if (expQ2.size() != 0) begin bad++; $display("[TB] FAIL rm_drain got=%0d left want=0", expQ2.size()); expQ2.delete(); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_partial();
        test_backpressure();
        test_lanes4();
        test_reset_midword();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
